instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Fetch stage sitting directly upstream of the program-memory ROM.
- Owns the program counter and drives the ROM byte address, rebased so the text segment starts at ROM word 0.
- Takes the combinational instruction back from the ROM and registers it into the IF/ID pipeline register.
- Supports decode-stage stall, execute-stage redirect (branch/jump) with flush, and range/alignment checking.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- MEMORY_DEPTH, 32, number of instruction words in the ROM.
- TEXT_BASE, 32'h0040_0000, reset PC value and byte address of ROM word 0.
- NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold PC and IF/ID contents (load-use hazard from decode).
- Redirect  input  1  branch taken / jump resolved; load RedirectAddress.
- RedirectAddress  input  DATA_WIDTH  byte target of the redirect.
- Instruction  input  DATA_WIDTH  ROM read data for MemAddress (combinational).
- MemAddress  output  DATA_WIDTH  PC - TEXT_BASE; feeds the ROM Address port.
- PC  output  DATA_WIDTH  current program counter (registered).
- IFID_Instruction  output  DATA_WIDTH  registered fetched instruction.
- IFID_PCPlus4  output  DATA_WIDTH  registered PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
- OutOfRange  output  1  combinational; MemAddress >= MEMORY_DEPTH*4.
- MisalignedFault  output  1  sticky; a redirect target had bits[1:0] != 0.
- FetchCount  output  32  count of valid instructions loaded into IF/ID.

Behaviour:
- Reset (sync, active-high, highest priority):
  - PC = TEXT_BASE.
  - IFID_Instruction = NOP_WORD, IFID_PCPlus4 = 0, IFID_Valid = 0.
  - MisalignedFault = 0, FetchCount = 0.
  - Reset asserted mid-stall or mid-redirect overrides both in that cycle.
- MemAddress = PC - TEXT_BASE, modulo 2^DATA_WIDTH. It is combinational from the PC register; the ROM returns Instruction in the same cycle.
- OutOfRange = (MemAddress >= MEMORY_DEPTH*4). This includes PC below TEXT_BASE, which wraps to a large value.
- Per rising edge, in priority order:
  1. reset.
  2. Redirect:
     - PC <= {RedirectAddress[31:2], 2'b00}.
     - IF/ID loads the bubble: NOP_WORD, Valid = 0, PCPlus4 = 0.
     - If RedirectAddress[1:0] != 0, MisalignedFault <= 1.
     - Redirect wins over a simultaneous Stall.
  3. Stall: PC, IF/ID and FetchCount hold.
  4. Normal:
     - PC <= PC + 4, wrapping at 2^DATA_WIDTH.
     - IFID_PCPlus4 <= PC + 4.
     - If OutOfRange = 0: IFID_Instruction <= Instruction, IFID_Valid <= 1, FetchCount += 1 (wraps at 2^32).
     - If OutOfRange = 1: IFID_Instruction <= NOP_WORD, IFID_Valid <= 0, FetchCount unchanged. The PC still advances.
- Latency: an instruction at PC appears on IFID_* one edge after PC presents it. Taken-redirect penalty is one bubble from this stage.
- MisalignedFault is cleared only by reset. PC is never misaligned (bits[1:0] always 00).
- Stall held indefinitely: outputs remain constant. On release, fetch resumes from the held PC with no duplicate or lost instruction.

Test Plan:
- Reset then 3 free-running cycles, ROM words 0..2 = 0x20080005, 0x20090003, 0x01095020:
  - PC goes 0x00400000 -> 0x0040000C.
  - MemAddress goes 0 -> 0xC.
  - IFID_Instruction shows the 3 words in order, with IFID_PCPlus4 = 0x00400004/08/0C.
  - FetchCount = 3.
- Stall for 2 cycles at PC = 0x00400008: PC and IF/ID hold 0x00400008 / 0x20090003 for both cycles. After release the next IF/ID is 0x01095020, with no repeat.
- Redirect = 1, RedirectAddress = 0x00400010, with Stall = 1 in the same cycle:
  - PC = 0x00400010 next edge.
  - IFID_Valid = 0, IFID_Instruction = 0.
  - FetchCount unchanged.
- Redirect to 0x00400006: PC = 0x00400004, MisalignedFault = 1. The fault stays 1 through subsequent fetches until reset clears it.
- Free-run past ROM end (PC = 0x00400080, MEMORY_DEPTH = 32):
  - OutOfRange = 1.
  - IF/ID loads a bubble with Valid = 0.
  - FetchCount stops incrementing; PC keeps incrementing by 4.
- Assert reset during a redirect cycle: PC = 0x00400000 and all IF/ID fields at their reset values.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage in front of the program-memory ROM. It owns the program
// counter, presents a ROM byte address rebased so TEXT_BASE maps to ROM
// word 0, and registers the combinational ROM read data into the IF/ID
// pipeline register. It supports decode-stage stall, execute-stage redirect
// with flush, and range/alignment checking.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset (highest priority)
//   Stall            hold PC, IF/ID and FetchCount
//   Redirect         load RedirectAddress into PC and flush IF/ID
//   RedirectAddress  byte target of the redirect
//   Instruction      ROM read data for MemAddress (same cycle)
//   MemAddress       PC - TEXT_BASE, drives the ROM address
//   PC               current program counter
//   IFID_Instruction registered fetched instruction
//   IFID_PCPlus4     registered PC+4 of that instruction
//   IFID_Valid       IF/ID holds a real instruction (0 = bubble)
//   OutOfRange       MemAddress lies beyond the ROM (combinational)
//   MisalignedFault  sticky: a redirect target was not word aligned
//   FetchCount       number of valid instructions loaded into IF/ID
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectAddress,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  OutOfRange,
    output logic                  MisalignedFault,
    output logic [31:0]           FetchCount
);

    localparam logic [DATA_WIDTH-1:0] ROM_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);

    // Byte offset into the ROM; a PC below TEXT_BASE wraps to a huge value
    // and is therefore caught by the same unsigned compare.
    function automatic logic beyond_rom(input logic [DATA_WIDTH-1:0] offset);
        return (offset >= ROM_BYTES);
    endfunction

    // Word-align a redirect target by clearing the byte-offset bits.
    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:2], 2'b00};
    endfunction

    logic [DATA_WIDTH-1:0] pc_p0;
    logic [DATA_WIDTH-1:0] mem_addr_p0;
    logic [DATA_WIDTH-1:0] pc_plus4_p0;
    logic                  oor_p0;

    logic [DATA_WIDTH-1:0] instr_p1;
    logic [DATA_WIDTH-1:0] pc_plus4_p1;
    logic                  vld_p1;
    logic                  fault_q;
    logic [31:0]           fetch_cnt_q;

    // ---- stage p0: PC presents an address, ROM answers combinationally ----
    assign mem_addr_p0 = pc_p0 - TEXT_BASE;
    assign pc_plus4_p0 = pc_p0 + DATA_WIDTH'(4);
    assign oor_p0      = beyond_rom(mem_addr_p0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= TEXT_BASE;
        end else if (Redirect) begin
            pc_p0 <= word_align(RedirectAddress);
        end else if (!Stall) begin
            // The PC advances even past the ROM end so software-visible
            // fetch order is unaffected by the range check.
            pc_p0 <= pc_plus4_p0;
        end
    end

    // ---- stage p1: IF/ID pipeline register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_p1    <= NOP_WORD;
            pc_plus4_p1 <= '0;
            vld_p1      <= 1'b0;
            fetch_cnt_q <= '0;
        end else if (Redirect) begin
            // Flush: the word presented this cycle is on the wrong path.
            instr_p1    <= NOP_WORD;
            pc_plus4_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (!Stall) begin
            pc_plus4_p1 <= pc_plus4_p0;
            if (oor_p0) begin
                instr_p1 <= NOP_WORD;
                vld_p1   <= 1'b0;
            end else begin
                instr_p1    <= Instruction;
                vld_p1      <= 1'b1;
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    // Sticky until reset; a stall does not mask a redirect's fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (Redirect && (RedirectAddress[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign MemAddress       = mem_addr_p0;
    assign PC               = pc_p0;
    assign OutOfRange       = oor_p0;
    assign IFID_Instruction = instr_p1;
    assign IFID_PCPlus4     = pc_plus4_p1;
    assign IFID_Valid       = vld_p1;
    assign MisalignedFault  = fault_q;
    assign FetchCount       = fetch_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset, Stall, Redirect;
    logic [31:0] RedirectAddress, Instruction;
    logic [31:0] MemAddress, PC, IFID_Instruction, IFID_PCPlus4, FetchCount;
    logic        IFID_Valid, OutOfRange, MisalignedFault;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [DEPTH];

    // Reference state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_fault;

    instruction_fetch_stage #(
        .DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .TEXT_BASE(BASE), .NOP_WORD(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
        .RedirectAddress(RedirectAddress), .Instruction(Instruction),
        .MemAddress(MemAddress), .PC(PC), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
        .OutOfRange(OutOfRange), .MisalignedFault(MisalignedFault),
        .FetchCount(FetchCount)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: garbage outside the array so a missed range check shows.
    always_comb begin
        Instruction = 32'hDEAD_BEEF;
        if (MemAddress < 32'(DEPTH * 4)) Instruction = rom[MemAddress[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] off;
        off = m_pc - BASE;
        check({tag, ".PC"}, PC, m_pc);
        check({tag, ".MemAddress"}, MemAddress, off);
        check({tag, ".OutOfRange"}, 32'(OutOfRange), 32'(off >= 32'(DEPTH * 4)));
        check({tag, ".IFID_Instruction"}, IFID_Instruction, m_instr);
        check({tag, ".IFID_PCPlus4"}, IFID_PCPlus4, m_pc4);
        check({tag, ".IFID_Valid"}, 32'(IFID_Valid), 32'(m_valid));
        check({tag, ".MisalignedFault"}, 32'(MisalignedFault), 32'(m_fault));
        check({tag, ".FetchCount"}, FetchCount, m_cnt);
    endtask

    // One clock edge: drive inputs, advance the model from the fetch rules,
    // then compare everything shortly after the edge.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic rd, input logic [31:0] ra);
        logic [31:0] off;
        reset = rst; Stall = st; Redirect = rd; RedirectAddress = ra;
        if (rst) begin
            m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
        end else if (rd) begin
            m_pc = ra - (ra % 4);
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (ra % 4 != 0) m_fault = 1;
        end else if (!st) begin
            off = m_pc - BASE;
            m_pc4 = m_pc + 4;
            if (off < DEPTH * 4) begin
                m_instr = rom[off / 4]; m_valid = 1; m_cnt = m_cnt + 1;
            end else begin
                m_instr = 0; m_valid = 0;
            end
            m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1; Stall = 0; Redirect = 0; RedirectAddress = 0;
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        rom[0] = 32'h2008_0005;
        rom[1] = 32'h2009_0003;
        rom[2] = 32'h0109_5020;
        m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_cnt = 'x; m_valid = 'x; m_fault = 'x;
        @(negedge clk);

        step("reset", 1, 0, 0, 0);
        check("reset.PC_const", PC, 32'h0040_0000);

        step("run1", 0, 0, 0, 0);
        step("run2", 0, 0, 0, 0);
        check("run2.PC_const", PC, 32'h0040_0008);
        check("run2.IFID_const", IFID_Instruction, 32'h2009_0003);

        step("stall1", 0, 1, 0, 0);
        step("stall2", 0, 1, 0, 0);
        check("stall2.PC_const", PC, 32'h0040_0008);
        check("stall2.IFID_const", IFID_Instruction, 32'h2009_0003);

        step("run3", 0, 0, 0, 0);
        check("run3.IFID_const", IFID_Instruction, 32'h0109_5020);
        check("run3.PCPlus4_const", IFID_PCPlus4, 32'h0040_000C);
        check("run3.PC_const", PC, 32'h0040_000C);
        check("run3.count_const", FetchCount, 32'd3);

        step("redir_stall", 0, 1, 1, 32'h0040_0010);
        check("redir_stall.PC_const", PC, 32'h0040_0010);
        check("redir_stall.count_const", FetchCount, 32'd3);

        step("redir_mis", 0, 0, 1, 32'h0040_0006);
        check("redir_mis.PC_const", PC, 32'h0040_0004);
        check("redir_mis.fault_const", 32'(MisalignedFault), 32'd1);
        for (int i = 0; i < 3; i++) step("post_mis", 0, 0, 0, 0);

        // Run off the end of the ROM.
        step("redir_end", 0, 0, 1, 32'h0040_0078);
        for (int i = 0; i < 5; i++) step("past_end", 0, 0, 0, 0);
        check("past_end.PC_const", PC, 32'h0040_008C);
        check("past_end.oor_const", 32'(OutOfRange), 32'd1);

        // Below TEXT_BASE wraps and is also out of range.
        step("redir_low", 0, 0, 1, 32'h003F_FFF8);
        for (int i = 0; i < 3; i++) step("below_base", 0, 0, 0, 0);

        // Randomized mix of stalls, redirects and the odd reset.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_st, r_rd;
            logic [31:0] r_ra;
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 7) == 0);
            r_ra  = BASE - 32'd16 + 32'($urandom_range(0, 160));
            step("random", r_rst, r_st, r_rd, r_ra);
        end

        // Reset during a redirect with a stall: reset wins.
        step("pre_rst", 0, 0, 1, 32'h0040_0033);
        step("rst_redir", 1, 1, 1, 32'h0040_0040);
        check("rst_redir.PC_const", PC, 32'h0040_0000);
        check("rst_redir.valid_const", 32'(IFID_Valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
